ped_request_unit: RTL and testbench



---
 rtl/ped_pkg.sv | 14 +
 rtl/btn_debounce.sv | 68 ++++++
 rtl/ped_request_unit.sv | 113 +++++++++++
 tb/tb_ped_request_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared types and defaults for the pedestrian request unit.
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLDOFF = 2'd2
  } ped_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 270000;
  localparam int HOLDOFF_CYCLES_DEF  = 27000000;
  localparam int REQ_COUNT_W         = 16;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stable-count debouncer and a
// one-cycle strobe on each debounced released-to-pressed transition.
module btn_debounce
  import ped_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic press_pulse_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          RELEASED = BTN_ACTIVE_LOW;

  logic          sync1_q, sync2_q;
  logic          vld1_q, vld2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          arm_q, arm_d;

  // A press only counts once a genuinely released button has been seen since
  // reset, so a button held through reset cannot raise a request by itself.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    arm_d   = arm_q | (vld2_q & (sync2_q == RELEASED));
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
      pulse_d = (sync2_q != RELEASED) & arm_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      level_q <= RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      vld1_q  <= 1'b1;
      vld2_q  <= vld1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      arm_q   <= arm_d;
    end
  end

  assign press_pulse_o = pulse_q;

endmodule

// File: rtl/ped_request_unit.sv
// Pedestrian request unit: debounced press -> latched req held until ack, then
// a hold-off window. Define PED_REQ_COUNT_EN to add the req_count output.
module ped_request_unit
  import ped_pkg::*;
#(
  parameter int   CLK_HZ          = 27000000,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int   HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF,
  parameter logic BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       ack,
  output logic       req,
  output logic       pending_led_n,
  output logic       busy,
`ifdef PED_REQ_COUNT_EN
  output logic [REQ_COUNT_W-1:0] req_count,
`endif
  output logic [1:0] dbg_state
);

  localparam int            HW        = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  if (CLK_HZ < 1) begin : g_bad_clk
    $error("CLK_HZ must be positive");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (HOLDOFF_CYCLES < 1) begin : g_bad_ho
    $error("HOLDOFF_CYCLES must be >= 1");
  end

  logic          press_pulse;
  ped_state_e    state_q;
  logic          req_q, busy_q;
  logic [HW-1:0] hold_cnt_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_deb (
    .clk          (clk),
    .rst          (rst),
    .btn_raw_i    (btn_raw),
    .press_pulse_o(press_pulse)
  );

  // ack has priority in REQ; presses outside IDLE are simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_pulse) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            state_q    <= HOLDOFF;
            req_q      <= 1'b0;
            hold_cnt_q <= '0;
          end
        end
        HOLDOFF: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          req_q      <= 1'b0;
          busy_q     <= 1'b0;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

`ifdef PED_REQ_COUNT_EN
  logic [REQ_COUNT_W-1:0] req_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_count_q <= '0;
    end else if ((state_q == IDLE) && press_pulse && (req_count_q != '1)) begin
      req_count_q <= req_count_q + REQ_COUNT_W'(1);
    end
  end

  assign req_count = req_count_q;
`endif

  assign req           = req_q;
  assign pending_led_n = ~req_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ped_request_unit.sv
// Directed bench for ped_request_unit with DEBOUNCE_CYCLES=8, HOLDOFF_CYCLES=20.
module tb_ped_request_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       ack;
  logic       req;
  logic       pending_led_n;
  logic       busy;
  logic [1:0] dbg_state;
`ifdef PED_REQ_COUNT_EN
  logic [15:0] req_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pulse_seen;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  ped_request_unit #(
    .CLK_HZ         (27000000),
    .DEBOUNCE_CYCLES(8),
    .HOLDOFF_CYCLES (20),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .ack          (ack),
    .req          (req),
    .pending_led_n(pending_led_n),
    .busy         (busy),
`ifdef PED_REQ_COUNT_EN
    .req_count    (req_count),
`endif
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (dut.press_pulse === 1'b1) pulse_seen++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = 1'b1;
    ack     = 1'b0;
    tick(3);
    rst = 1'b0;
    check_eq("rst_req", req, 0);
    check_eq("rst_led", pending_led_n, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", dbg_state, S_IDLE);
`ifdef PED_REQ_COUNT_EN
    check_eq("rst_count", req_count, 0);
`endif
    tick(5);

    // bounce every 3 cycles for 40 cycles
    pulse_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn_raw = ~btn_raw;
      tick_watch(1);
    end
    btn_raw = 1'b1;
    tick_watch(15);
    check_eq("bounce_pulse", pulse_seen, 0);
    check_eq("bounce_req", req, 0);

    // press one cycle short of the debounce window
    btn_raw = 1'b0;
    tick_watch(7);
    btn_raw = 1'b1;
    tick_watch(15);
    check_eq("short_pulse", pulse_seen, 0);
    check_eq("short_req", req, 0);

    // clean press: req after DEBOUNCE_CYCLES+3 = 11 edges
    btn_raw = 1'b0;
    tick(10);
    check_eq("clean_req_early", req, 0);
    check_eq("clean_pulse", dut.press_pulse, 1);
    tick(1);
    check_eq("clean_req", req, 1);
    check_eq("clean_led", pending_led_n, 0);
    check_eq("clean_busy", busy, 1);
    check_eq("clean_state", dbg_state, S_REQ);
    tick(5);
    check_eq("clean_hold", req, 1);
    btn_raw = 1'b1;
    tick(12);
    check_eq("release_in_req", req, 1);

    // handshake and hold-off with a press inside the window
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check_eq("ack_req", req, 0);
    check_eq("ack_busy", busy, 1);
    check_eq("ack_state", dbg_state, S_HOLD);
    check_eq("ack_led", pending_led_n, 1);
    tick(1);
    btn_raw = 1'b0;
    tick(18);
    check_eq("hold_busy_last", busy, 1);
    check_eq("hold_req", req, 0);
    tick(1);
    check_eq("hold_end_busy", busy, 0);
    check_eq("hold_end_state", dbg_state, S_IDLE);
    tick(5);
    check_eq("held_no_rereq", req, 0);
    ack = 1'b1;
    tick(3);
    ack = 1'b0;
    check_eq("idle_ack_ignored", dbg_state, S_IDLE);
    btn_raw = 1'b1;
    tick(12);
    check_eq("after_release", req, 0);
    btn_raw = 1'b0;
    tick(10);
    check_eq("fresh_early", req, 0);
    tick(1);
    check_eq("fresh_req", req, 1);

    // collision: press_pulse and ack on the same edge in REQ
    btn_raw = 1'b1;
    tick(12);
    btn_raw = 1'b0;
    tick(10);
    check_eq("coll_pulse", dut.press_pulse, 1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check_eq("coll_state", dbg_state, S_HOLD);
    check_eq("coll_req", req, 0);
    tick(25);
    check_eq("coll_after_state", dbg_state, S_IDLE);
    check_eq("coll_after_req", req, 0);
    check_eq("coll_after_busy", busy, 0);

    // async reset while req is high
    btn_raw = 1'b1;
    tick(12);
    btn_raw = 1'b0;
    tick(11);
    check_eq("pre_rst_req", req, 1);
`ifdef PED_REQ_COUNT_EN
    check_eq("count_three", req_count, 3);
`endif
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_req", req, 0);
    check_eq("async_led", pending_led_n, 1);
    check_eq("async_busy", busy, 0);
    check_eq("async_state", dbg_state, S_IDLE);
`ifdef PED_REQ_COUNT_EN
    check_eq("async_count", req_count, 0);
`endif
    tick(2);
    rst = 1'b0;
    tick(30);
    check_eq("held_thru_rst", req, 0);
    btn_raw = 1'b1;
    tick(12);
    btn_raw = 1'b0;
    tick(10);
    check_eq("post_rst_early", req, 0);
    tick(1);
    check_eq("post_rst_req", req, 1);
`ifdef PED_REQ_COUNT_EN
    check_eq("post_rst_count", req_count, 1);
`endif
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check_eq("final_state", dbg_state, S_HOLD);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
